// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared types and constants for the sliced add/subtract engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 8;

    // Slice index width; a single-slice engine still needs a 1-bit index.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_lookahead.sv
// ============================================================================
// Module   : alu_lookahead
// Brief    : 8-bit carry-lookahead stage; carrys[i] is the carry out of bit i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_lookahead
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] p,
    input  logic [SLICE_W-1:0] g,
    input  logic               c_in,
    output logic [SLICE_W-1:0] carrys
);

    // Each carry is a flat sum of products: g[i] | p[i]g[i-1] | ... | p[i..0]c_in.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_carry
        logic w_acc;
        logic w_prop;

        always_comb begin
            w_acc  = g[i];
            w_prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc  = w_acc | (w_prop & g[j]);
                w_prop = w_prop & p[j];
            end
            w_acc = w_acc | (w_prop & c_in);
        end

        assign carrys[i] = w_acc;
    end

endmodule

`default_nettype wire

// File: rtl/alu_slice_adder_seq.sv
// ============================================================================
// Module   : alu_slice_adder_seq
// Brief    : Sequential WIDTH-bit add/subtract, one 8-bit lookahead slice per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_slice_adder_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_zero;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_carrys;
    logic [SLICE_W-1:0] w_slice_sum;
    logic [WIDTH-1:0]   w_sum_next;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_step   = (r_state == ST_RUN);
    assign w_last   = (r_idx == c_last_idx);

    assign w_p = r_op_a[int'(r_idx) * SLICE_W +: SLICE_W] ^ r_op_b[int'(r_idx) * SLICE_W +: SLICE_W];
    assign w_g = r_op_a[int'(r_idx) * SLICE_W +: SLICE_W] & r_op_b[int'(r_idx) * SLICE_W +: SLICE_W];

    alu_lookahead u_lookahead (
        .p      (w_p),
        .g      (w_g),
        .c_in   (r_carry),
        .carrys (w_carrys)
    );

    assign w_slice_sum = w_p ^ {w_carrys[SLICE_W-2:0], r_carry};

    // SUM as it will look after this slice lands; ZERO is judged on the full word.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[int'(r_idx) * SLICE_W +: SLICE_W] = w_slice_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + ~borrow, so the inverted B and carry are folded in here.
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= c_in ^ sub;
            r_idx   <= '0;
        end else if (w_step) begin
            r_sum   <= w_sum_next;
            r_carry <= w_carrys[SLICE_W-1];
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_c_out <= w_carrys[SLICE_W-1];
                r_ovf   <= w_carrys[SLICE_W-1] ^ w_carrys[SLICE_W-2];
                r_zero  <= (w_sum_next == '0);
            end
        end
    end

    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;
    assign zero     = r_zero;

`ifdef FORMAL
    logic [WIDTH:0] r_ref;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= '0;
        end else if (w_accept) begin
            r_ref <= {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, c_in ^ sub};
        end
    end

    always_comb begin
        if (!rst) begin
            a_res_valid_done : assert (!res_valid || (r_state == ST_DONE));
            a_req_ready_idle : assert (!req_ready || (r_state == ST_IDLE));
            if (r_state == ST_DONE) begin
                a_result : assert ({r_c_out, r_sum} == r_ref);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_slice_adder_seq.sv
// ============================================================================
// Module   : tb_alu_slice_adder_seq
// Brief    : Self-checking bench for the sliced adder at WIDTH=32 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_slice_adder_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rv32 = 1'b0, rr32, sub32 = 1'b0, cin32 = 1'b0, resv32, resr32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        cout32, ovf32, zero32;

    logic        rv8 = 1'b0, rr8, sub8 = 1'b0, cin8 = 1'b0, resv8, resr8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        cout8, ovf8, zero8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_slice_adder_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rr32),
        .a(a32), .b(b32), .sub(sub32), .c_in(cin32),
        .res_valid(resv32), .res_ready(resr32),
        .sum(sum32), .c_out(cout32), .overflow(ovf32), .zero(zero32)
    );

    alu_slice_adder_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .req_valid(rv8), .req_ready(rr8),
        .a(a8), .b(b8), .sub(sub8), .c_in(cin8),
        .res_valid(resv8), .res_ready(resr8),
        .sum(sum8), .c_out(cout8), .overflow(ovf8), .zero(zero8)
    );

    // Reference: unsigned result modulo 2^w, carry/no-borrow from magnitude compare,
    // overflow from the true signed result leaving the w-bit signed range.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit s, input bit ci, output longint unsigned res,
                                  output bit co, output bit ov, output bit z);
        longint unsigned m    = 64'd1 << w;
        longint          half = longint'(m >> 1);
        longint          sa, sb, v;
        longint unsigned u;
        sa = (a >= (m >> 1)) ? longint'(a) - longint'(m) : longint'(a);
        sb = (b >= (m >> 1)) ? longint'(b) - longint'(m) : longint'(b);
        if (!s) begin
            u  = a + b + longint'(ci);
            co = (u >= m);
            v  = sa + sb + longint'(ci);
        end else begin
            co = (a >= b + longint'(ci));
            u  = a + m - b - longint'(ci);
            v  = sa - sb - longint'(ci);
        end
        res = u % m;
        ov  = (v >= half) || (v < -half);
        z   = (res == 0);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 11))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit s, input bit ci,
                        input logic [31:0] es, input bit eco, input bit eov, input bit ez,
                        input string nm);
        int lat;
        @(negedge clk);
        n_checks++;
        if (rr32 !== 1'b1) begin n_fail++; $display("FAIL %s req_ready idle: got %b want 1", nm, rr32); end
        a32 = a; b32 = b; sub32 = s; cin32 = ci; rv32 = 1'b1;
        @(negedge clk);
        rv32 = 1'b0;
        lat  = 0;
        while (resv32 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
        n_checks++;
        if (sum32 !== es) begin n_fail++; $display("FAIL %s sum: got %h want %h", nm, sum32, es); end
        n_checks++;
        if (cout32 !== eco) begin n_fail++; $display("FAIL %s c_out: got %b want %b", nm, cout32, eco); end
        n_checks++;
        if (ovf32 !== eov) begin n_fail++; $display("FAIL %s overflow: got %b want %b", nm, ovf32, eov); end
        n_checks++;
        if (zero32 !== ez) begin n_fail++; $display("FAIL %s zero: got %b want %b", nm, zero32, ez); end
        resr32 = 1'b1;
        @(negedge clk);
        resr32 = 1'b0;
        n_checks++;
        if (resv32 !== 1'b0 || rr32 !== 1'b1 || sum32 !== es) begin
            n_fail++;
            $display("FAIL %s after handshake: res_valid=%b req_ready=%b sum=%h want 0 1 %h",
                     nm, resv32, rr32, sum32, es);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit ci);
        int              lat;
        longint unsigned es;
        bit              eco, eov, ez;
        model(8, longint'(a), longint'(b), s, ci, es, eco, eov, ez);
        @(negedge clk);
        a8 = a; b8 = b; sub8 = s; cin8 = ci; rv8 = 1'b1;
        @(negedge clk);
        rv8 = 1'b0;
        lat = 0;
        while (resv8 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 1 || sum8 !== es[7:0] || cout8 !== eco || ovf8 !== eov || zero8 !== ez) begin
            n_fail++;
            $display("FAIL w8 %h %s %h cin=%b: lat=%0d sum=%h c=%b v=%b z=%b want lat=1 sum=%h c=%b v=%b z=%b",
                     a, s ? "-" : "+", b, ci, lat, sum8, cout8, ovf8, zero8, es[7:0], eco, eov, ez);
        end
        resr8 = 1'b1;
        @(negedge clk);
        resr8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rv32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sum32 !== '0 || cout32 !== 1'b0 || ovf32 !== 1'b0 || zero32 !== 1'b0 || resv32 !== 1'b0 || rr32 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset state: sum=%h c=%b v=%b z=%b rv=%b rr=%b want 0 0 0 0 0 1",
                     sum32, cout32, ovf32, zero32, resv32, rr32);
        end
        rv32 = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rr32 !== 1'b1) begin n_fail++; $display("FAIL reset req ignored: req_ready=%b want 1", rr32); end
    endtask

    task automatic test_directed();
        op32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, "ff_plus_1");
        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "ripple_all");
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "pos_ovf");
        op32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "neg_ovf");
        op32(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_5_7");
        op32(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, "sub_7_5_b");
    endtask

    task automatic test_backpressure();
        int lat = 0;
        @(negedge clk);
        a32 = 32'h1234_5678; b32 = 32'h1111_1111; sub32 = 1'b0; cin32 = 1'b0; rv32 = 1'b1;
        @(negedge clk);
        rv32 = 1'b0;
        while (resv32 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            rv32 = ~rv32;
            a32  = $urandom;
            b32  = $urandom;
            @(negedge clk);
            n_checks++;
            if (resv32 !== 1'b1 || rr32 !== 1'b0 || sum32 !== 32'h2345_6789 || cout32 !== 1'b0 || zero32 !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: rv=%b rr=%b sum=%h c=%b z=%b want 1 0 23456789 0 0",
                         i, resv32, rr32, sum32, cout32, zero32);
            end
        end
        rv32   = 1'b0;
        resr32 = 1'b1;
        @(negedge clk);
        resr32 = 1'b0;
        n_checks++;
        if (resv32 !== 1'b0 || rr32 !== 1'b1 || sum32 !== 32'h2345_6789) begin
            n_fail++;
            $display("FAIL backpressure release: rv=%b rr=%b sum=%h want 0 1 23456789", resv32, rr32, sum32);
        end
    endtask

    task automatic test_reset_in_run();
        int seen = 0;
        @(negedge clk);
        a32 = 32'hAAAA_AAAA; b32 = 32'h1111_1111; sub32 = 1'b0; cin32 = 1'b0; rv32 = 1'b1;
        @(negedge clk);
        rv32 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (sum32 !== '0 || cout32 !== 1'b0 || ovf32 !== 1'b0 || zero32 !== 1'b0 || resv32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset in run: sum=%h c=%b v=%b z=%b rv=%b want all 0",
                     sum32, cout32, ovf32, zero32, resv32);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resv32 === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL aborted op: res_valid seen %0d cycles want 0", seen); end
        op32(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, "one_plus_two");
    endtask

    task automatic test_random32(input int n);
        logic [31:0]     ra, rb;
        bit              rs, rc, eco, eov, ez;
        longint unsigned es;
        for (int i = 0; i < n; i++) begin
            ra = pick32();
            rb = pick32();
            rs = 1'($urandom);
            rc = 1'($urandom);
            model(32, longint'(ra), longint'(rb), rs, rc, es, eco, eov, ez);
            op32(ra, rb, rs, rc, es[31:0], eco, eov, ez, "rand32");
        end
    endtask

    task automatic test_random8(input int n);
        for (int i = 0; i < n; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_in_run();
        fork
            test_random32(4000);
            test_random8(6000);
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
